mo_line_buffer: RTL and testbench
=================================

Name: mo_line_buffer

Overview:
- Double-buffered (ping-pong) motion-object line buffer that produces the 4-bit motion video pixel MV[3:0] consumed by the colour memory stage.
- During line N the sprite renderer writes pixels for line N+1 into the back bank, while the front bank is scanned out at pixel rate with clear-after-read.
- Banks swap on every line_start pulse.

Parameters:
- WIDTH_X, 8, pixel X address width (256 pixels per bank).
- CLEAR_VAL, 4'hF, value that means "no sprite pixel". Used for the reset fill, the clear-after-read and the idle output.
- HSTART, 8'd0, X address loaded into the read counter at line_start.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce5  in  1  pixel-rate clock enable; one read per asserted cycle
- line_start  in  1  single-cycle pulse: swap banks and reload the read counter
- flip  in  1  1 = read counter decrements (screen flip); sampled at line_start
- wr_valid  in  1  sprite pixel write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_x  in  8  target X of the pixel in the back bank
- wr_pix  in  4  sprite pixel; a value equal to CLEAR_VAL is transparent and is not written
- mv  out  4  motion video pixel to the colour memory stage (MV)
- busy  out  1  high during the post-reset clear sweep

Behaviour:
- Reset (synchronous):
  - bank_sel=0, rd_x=HSTART, mv=CLEAR_VAL, wr_ready=0, busy=1, write pipeline invalid.
  - FSM enters CLEAR.
- FSM states:
  - CLEAR: an 8-bit sweep counter writes CLEAR_VAL to address k of both banks every clk, independent of ce5. After 256 cycles (k=255) go to RUN; busy falls on the first RUN cycle.
  - RUN: normal operation. Reset asserted in any state re-enters CLEAR and restarts the sweep at 0.
- Swap:
  - line_start in RUN toggles bank_sel, loads rd_x=HSTART and latches flip.
  - line_start in CLEAR is ignored.
  - line_start has priority over a coincident ce5 read; no read happens that cycle.
- Read path (front bank = bank_sel):
  - On ce5 in RUN, read front[rd_x] and register it to mv one clk later (latency 1).
  - In the same cycle write CLEAR_VAL to front[rd_x], then rd_x += 1 (or -= 1 if flip latched). Wraps modulo 256.
  - mv holds its value between ce5 pulses.
- Write path (back bank = ~bank_sel), two-stage read-modify-write, first-written-wins priority:
  - S1: on accept, latch x, pix and bank id; read back[x].
  - S2: write pix only if the stored value == CLEAR_VAL and pix != CLEAR_VAL.
  - Hazard: if S2 writes address x and S1 holds the same x and bank, S1's compare uses forwarded "occupied" status. Back-to-back writes to one address therefore keep the first non-transparent pixel.
  - The bank id is captured at S1. A write in flight across line_start completes into its original bank.
- wr_ready:
  - 1 in RUN, except 0 in the cycle line_start is high.
  - 0 in CLEAR.
  - No other backpressure; one write per clk sustained.
- The read and write ports target different banks, so they never conflict. Each bank is a 256x4 RAM with one port used by each side (bank roles swap).

Decomposition:
- Shared package: CLEAR_VAL default, the pixel-width constant (4), and the FSM state enum {CLEAR, RUN}.
- One natural sub-module: mo_line_ram, a 256x4 single-clock RAM with a synchronous read port and a write port. Instantiate it twice. The top holds the FSM, counters, RMW pipeline and port muxing.

Test Plan:
- Reset held 3 clk, then released → busy=1 for 256 clk, wr_ready=0, mv=F. After the sweep busy=0, and reading any X of both banks returns F.
- Write x=10 pix=3, line_start, 11 ce5 pulses → mv=3 one clk after the 11th pulse (rd_x=10), F at all other X. Second line read of x=10 returns F (cleared after read).
- Back-to-back writes x=20 pix=5 then x=20 pix=9, line_start, read → mv=5 at x=20 (first wins via forwarding).
- Write pix=F to x=30 over an existing pix=2 → x=30 still reads 2. Transparent write is ignored.
- flip=1 at line_start with HSTART=0 → read order 0,255,254,…; pixel written at x=255 appears on the 2nd ce5 read.
- line_start coincident with ce5 and with an in-flight S2 write → no read or clear that cycle, wr_ready=0 that cycle, in-flight pixel lands in the old back bank (now front) and is output on the current line.

Source files
------------

// File: rtl/mo_line_buffer_pkg.sv
// mo_line_buffer_pkg: shared pixel width, transparent value and FSM states for the line buffer.
package mo_line_buffer_pkg;
  localparam int PIX_W = 4;
  localparam logic [PIX_W-1:0] CLEAR_VAL_DEF = 4'hF;
  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/mo_line_ram.sv
// mo_line_ram: single-clock pixel RAM with a synchronous read port and an independent write port.
module mo_line_ram
  import mo_line_buffer_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/mo_line_buffer.sv
// mo_line_buffer: ping-pong motion-object line buffer; front bank scanned out with clear-after-read,
// back bank filled by a first-written-wins read-modify-write pipeline.
module mo_line_buffer
  import mo_line_buffer_pkg::*;
#(
  parameter int                 WIDTH_X   = 8,
  parameter logic [PIX_W-1:0]   CLEAR_VAL = CLEAR_VAL_DEF,
  parameter logic [WIDTH_X-1:0] HSTART    = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce5,
  input  logic               line_start,
  input  logic               flip,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WIDTH_X-1:0] wr_x,
  input  logic [PIX_W-1:0]   wr_pix,
  output logic [PIX_W-1:0]   mv,
  output logic               busy
);
  state_e state_q, state_d;
  logic [WIDTH_X-1:0] sweep_q, rd_x_q, rd_x_d, s1_x_q, s2_x_q;
  logic [PIX_W-1:0] mv_q, s1_pix_q;
  logic [PIX_W-1:0] rdata [2];
  logic bank_sel_q, flip_q, rd_pend_q, s1_v_q, s1_bank_q, s2_wr_q, s2_bank_q;
  logic in_run, swap, rd_fire, accept, s1_occ, s1_we;
  always_comb begin
    in_run   = state_q == RUN;
    swap     = in_run && line_start;
    rd_fire  = in_run && ce5 && !line_start;
    wr_ready = in_run && !line_start;
    accept   = wr_valid && wr_ready;
    busy     = !in_run;
    state_d  = (state_q == CLEAR && &sweep_q) ? RUN : state_q;
    rd_x_d   = swap ? HSTART : rd_fire ? (flip_q ? rd_x_q - 1'b1 : rd_x_q + 1'b1) : rd_x_q;
    // last cycle's write to the same slot is not yet visible in the RAM read data
    s1_occ   = rdata[s1_bank_q] != CLEAR_VAL || (s2_wr_q && s2_x_q == s1_x_q && s2_bank_q == s1_bank_q);
    s1_we    = s1_v_q && !s1_occ && s1_pix_q != CLEAR_VAL;
    mv       = rd_pend_q ? rdata[bank_sel_q] : mv_q;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic front;
    assign front = bank_sel_q == 1'(b);
    mo_line_ram #(.AW(WIDTH_X)) u_ram (
      .clk     (clk),
      .we_i    (!in_run || (front ? rd_fire : s1_we && s1_bank_q == 1'(b))),
      .waddr_i (!in_run ? sweep_q : front ? rd_x_q : s1_x_q),
      .wdata_i ((!in_run || front) ? CLEAR_VAL : s1_pix_q),
      .raddr_i (front ? rd_x_q : wr_x),
      .rdata_o (rdata[b])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      sweep_q    <= '0;
      bank_sel_q <= 1'b0;
      rd_x_q     <= HSTART;
      flip_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      mv_q       <= CLEAR_VAL;
      s1_v_q     <= 1'b0;
      s2_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= in_run ? '0 : sweep_q + 1'b1;
      bank_sel_q <= bank_sel_q ^ swap;
      rd_x_q     <= rd_x_d;
      flip_q     <= swap ? flip : flip_q;
      rd_pend_q  <= rd_fire;
      mv_q       <= mv;
      s1_v_q     <= accept;
      s2_wr_q    <= s1_we;
    end
    s1_x_q    <= wr_x;
    s1_pix_q  <= wr_pix;
    s1_bank_q <= ~bank_sel_q;
    s2_x_q    <= s1_x_q;
    s2_bank_q <= s1_bank_q;
  end
endmodule

// File: tb/tb_mo_line_buffer.sv
// tb_mo_line_buffer: directed stimulus against a per-cycle behavioural model of the line buffer.
module tb_mo_line_buffer;
  logic clk = 1'b0, reset = 1'b1, ce5 = 1'b0, line_start = 1'b0, flip = 1'b0, wr_valid = 1'b0;
  logic [7:0] wr_x = 8'd0;
  logic [3:0] wr_pix = 4'd0;
  logic wr_ready, busy;
  logic [3:0] mv;
  int vectors = 0, errors = 0;
  logic [3:0] m_bank [2][256];
  bit m_sel, m_flip;
  logic [7:0] m_rdx;
  logic [3:0] m_mv;
  int m_left;
  always #5 clk = ~clk;
  mo_line_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .ce5        (ce5),
    .line_start (line_start),
    .flip       (flip),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_pix     (wr_pix),
    .mv         (mv),
    .busy       (busy)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_left = 256;
    m_sel  = 1'b0;
    m_rdx  = 8'd0;
    m_flip = 1'b0;
    m_mv   = 4'hF;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) m_bank[i][j] = 4'hF;
  endtask
  // Compare mid-cycle, then advance the model by what this cycle's inputs do at the edge.
  task automatic step();
    bit back;
    #4;
    chk("mv", 8'(mv), 8'(m_mv));
    chk("busy", 8'(busy), 8'(m_left > 0));
    chk("wr_ready", 8'(wr_ready), 8'(m_left == 0 && !line_start));
    back = ~m_sel;
    if (reset) model_reset();
    else if (m_left > 0) m_left--;
    else begin
      if (wr_valid && !line_start && wr_pix != 4'hF && m_bank[back][wr_x] == 4'hF)
        m_bank[back][wr_x] = wr_pix;
      if (line_start) begin
        m_sel  = ~m_sel;
        m_rdx  = 8'd0;
        m_flip = flip;
      end else if (ce5) begin
        m_mv = m_bank[m_sel][m_rdx];
        m_bank[m_sel][m_rdx] = 4'hF;
        m_rdx = m_flip ? m_rdx - 8'd1 : m_rdx + 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic wr(input logic [7:0] x, input logic [3:0] p);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_pix   = p;
    step();
    wr_valid = 1'b0;
  endtask
  task automatic ls(input bit f);
    line_start = 1'b1;
    flip       = f;
    step();
    line_start = 1'b0;
    flip       = 1'b0;
  endtask
  task automatic rd(input int n);
    ce5 = 1'b1;
    repeat (n) step();
    ce5 = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    model_reset();
    idle(2);
    reset = 1'b0;
    idle(255);
    chk("busy_during_sweep", 8'(busy), 8'h1);
    chk("ready_during_sweep", 8'(wr_ready), 8'h0);
    idle(1);
    chk("busy_after_sweep", 8'(busy), 8'h0);
    chk("ready_after_sweep", 8'(wr_ready), 8'h1);
    chk("mv_idle", 8'(mv), 8'hF);
    ls(0); rd(256);
    ls(0); rd(256);
    chk("swept_bank_reads_f", 8'(mv), 8'hF);
    wr(8'd10, 4'h3); ls(0);
    rd(10);
    chk("x9_transparent", 8'(mv), 8'hF);
    rd(1);
    chk("x10_pixel", 8'(mv), 8'h3);
    rd(245);
    ls(0); rd(256);
    ls(0); rd(11);
    chk("x10_cleared_after_read", 8'(mv), 8'hF);
    rd(245);
    wr(8'd20, 4'h5); wr(8'd20, 4'h9); ls(0);
    rd(21);
    chk("back_to_back_first_wins", 8'(mv), 8'h5);
    rd(235);
    wr(8'd30, 4'h2); idle(1); wr(8'd30, 4'hF); idle(2); wr(8'd30, 4'h7); ls(0);
    rd(31);
    chk("transparent_and_occupied", 8'(mv), 8'h2);
    rd(225);
    wr(8'd255, 4'h6); ls(1);
    rd(1);
    chk("flip_x0", 8'(mv), 8'hF);
    rd(1);
    chk("flip_x255", 8'(mv), 8'h6);
    rd(254);
    wr(8'd0, 4'hA);
    line_start = 1'b1;
    ce5        = 1'b1;
    wr_valid   = 1'b1;
    wr_x       = 8'd5;
    wr_pix     = 4'hC;
    #1;
    chk("ready_low_at_swap", 8'(wr_ready), 8'h0);
    step();
    line_start = 1'b0;
    wr_valid   = 1'b0;
    rd(1);
    chk("inflight_lands_in_front", 8'(mv), 8'hA);
    rd(5);
    chk("write_at_swap_dropped", 8'(mv), 8'hF);
    rd(250);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
